// File: rtl/clk_en_sched.sv
// Single-clock enable scheduler: programmable 2^shift strobes for the mult,
// sample and ADSR datapaths, with ADSR-before-sample ordering on collisions.
module clk_en_sched #(
  parameter int CNT_W            = 18,
  parameter int MULT_SHIFT_DEF   = 5,
  parameter int SAMPLE_SHIFT_DEF = 9,
  parameter int ADSR_SHIFT_DEF   = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_sel,
  input  logic [4:0] cfg_shift,
  output logic       cfg_err,
  output logic       mult_en,
  output logic       sample_en,
  output logic       adsr_en,
  output logic [4:0] shift_mult,
  output logic [4:0] shift_sample,
  output logic [4:0] shift_adsr
);

  localparam int NCH = 3;
  localparam int CH_MULT   = 0;
  localparam int CH_SAMPLE = 1;
  localparam int CH_ADSR   = 2;

  localparam logic [4:0] DEF_MULT   = 5'(MULT_SHIFT_DEF);
  localparam logic [4:0] DEF_SAMPLE = 5'(SAMPLE_SHIFT_DEF);
  localparam logic [4:0] DEF_ADSR   = 5'(ADSR_SHIFT_DEF);
  localparam logic [5:0] MAX_SHIFT  = 6'(CNT_W);

  typedef enum logic {
    SLOT_FREE,
    SLOT_PEND
  } slot_t;

  slot_t            slot_q, slot_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic [4:0]       pend_shift_q, pend_shift_d;

  logic [4:0]       shift_q [NCH];
  logic [4:0]       shift_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   apply;
  logic             accept;
  logic             illegal;

  logic             defer_q, defer_d;
  logic             mult_q, mult_d;
  logic             sample_q, sample_d;
  logic             adsr_q, adsr_d;
  logic             err_q, err_d;

  // Computed one bit wider so that shift == CNT_W still yields all-ones.
  function automatic logic [CNT_W-1:0] reload_of(input logic [4:0] s);
    logic [CNT_W:0] full;
    full = ((CNT_W+1)'(1) << s) - (CNT_W+1)'(1);
    return full[CNT_W-1:0];
  endfunction

  always_comb begin
    accept  = cfg_valid && (slot_q == SLOT_FREE);
    illegal = (cfg_sel == 2'd3) || ({1'b0, cfg_shift} > MAX_SHIFT);

    raw   = '0;
    apply = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      raw[ch]   = run && (cnt_q[ch] == '0);
      // A pending shift lands only on a reload edge so no period is cut short.
      apply[ch] = (slot_q == SLOT_PEND) && (pend_sel_q == 2'(ch)) &&
                  (!run || raw[ch]);
      shift_d[ch] = apply[ch] ? pend_shift_q : shift_q[ch];
      cnt_d[ch]   = (!run || raw[ch]) ? reload_of(shift_d[ch])
                                      : cnt_q[ch] - CNT_W'(1);
    end
  end

  // Config slot FSM: holds one accepted request until its channel reloads.
  always_comb begin
    slot_d       = slot_q;
    pend_sel_d   = pend_sel_q;
    pend_shift_d = pend_shift_q;
    err_d        = accept && illegal;

    case (slot_q)
      SLOT_FREE: begin
        if (accept && !illegal) begin
          slot_d       = SLOT_PEND;
          pend_sel_d   = cfg_sel;
          pend_shift_d = cfg_shift;
        end
      end
      SLOT_PEND: begin
        if (|apply) begin
          slot_d = SLOT_FREE;
        end
      end
      default: slot_d = SLOT_FREE;
    endcase
  end

  // A sample strobe coinciding with ADSR is pushed one cycle later so the
  // envelope is updated first; a fresh sample strobe there merges with it.
  always_comb begin
    mult_d   = raw[CH_MULT];
    adsr_d   = raw[CH_ADSR];
    defer_d  = raw[CH_SAMPLE] && raw[CH_ADSR];
    sample_d = (raw[CH_SAMPLE] && !raw[CH_ADSR]) || defer_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q             <= SLOT_FREE;
      pend_sel_q         <= '0;
      pend_shift_q       <= '0;
      shift_q[CH_MULT]   <= DEF_MULT;
      shift_q[CH_SAMPLE] <= DEF_SAMPLE;
      shift_q[CH_ADSR]   <= DEF_ADSR;
      cnt_q[CH_MULT]     <= reload_of(DEF_MULT);
      cnt_q[CH_SAMPLE]   <= reload_of(DEF_SAMPLE);
      cnt_q[CH_ADSR]     <= reload_of(DEF_ADSR);
      defer_q            <= 1'b0;
      mult_q             <= 1'b0;
      sample_q           <= 1'b0;
      adsr_q             <= 1'b0;
      err_q              <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      pend_sel_q   <= pend_sel_d;
      pend_shift_q <= pend_shift_d;
      for (int ch = 0; ch < NCH; ch++) begin
        shift_q[ch] <= shift_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      defer_q  <= defer_d;
      mult_q   <= mult_d;
      sample_q <= sample_d;
      adsr_q   <= adsr_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready    = (slot_q == SLOT_FREE);
  assign cfg_err      = err_q;
  assign mult_en      = mult_q;
  assign sample_en    = sample_q;
  assign adsr_en      = adsr_q;
  assign shift_mult   = shift_q[CH_MULT];
  assign shift_sample = shift_q[CH_SAMPLE];
  assign shift_adsr   = shift_q[CH_ADSR];

endmodule

// File: tb/tb_clk_en_sched.sv
// Testbench for clk_en_sched: config vector table, directed period/ordering
// sequences and randomized traffic against a period-start reference model.
module tb_clk_en_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_shift;
  logic       cfg_err;
  logic       mult_en;
  logic       sample_en;
  logic       adsr_en;
  logic [4:0] shift_mult;
  logic [4:0] shift_sample;
  logic [4:0] shift_adsr;

  clk_en_sched dut (
    .clk          (clk),
    .rstn         (rstn),
    .run          (run),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sel      (cfg_sel),
    .cfg_shift    (cfg_shift),
    .cfg_err      (cfg_err),
    .mult_en      (mult_en),
    .sample_en    (sample_en),
    .adsr_en      (adsr_en),
    .shift_mult   (shift_mult),
    .shift_sample (shift_sample),
    .shift_adsr   (shift_adsr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel remembers the cycle its current period
  // started; a strobe is due when 2^shift cycles of that period have elapsed.
  int m_cyc;
  int m_start [3];
  int m_shift [3];
  bit m_pend;
  int m_psel;
  int m_pshift;
  bit m_defer;
  bit m_en [3];
  bit m_err;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] shift;
    logic       exp_err;
    logic       exp_ready;
    int         exp_m;
    int         exp_s;
    int         exp_a;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shift[0] = 5;
    m_shift[1] = 9;
    m_shift[2] = 18;
    for (int ch = 0; ch < 3; ch++) begin
      m_start[ch] = m_cyc;
      m_en[ch]    = 1'b0;
    end
    m_pend  = 1'b0;
    m_defer = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit raw [3];
    bit app [3];
    bit rdy;
    rdy = !m_pend;
    for (int ch = 0; ch < 3; ch++) begin
      raw[ch] = run && ((m_cyc - m_start[ch]) == (1 << m_shift[ch]) - 1);
      app[ch] = m_pend && (m_psel == ch) && (!run || raw[ch]);
    end
    m_en[0] = raw[0];
    m_en[2] = raw[2];
    m_en[1] = (raw[1] && !raw[2]) || m_defer;
    m_defer = raw[1] && raw[2];
    m_err   = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      if (app[ch]) begin
        m_shift[ch] = m_pshift;
        m_pend      = 1'b0;
      end
      if (!run || raw[ch]) m_start[ch] = m_cyc + 1;
    end
    if (cfg_valid && rdy) begin
      if (int'(cfg_sel) == 3 || int'(cfg_shift) > 18) begin
        m_err = 1'b1;
      end else begin
        m_pend   = 1'b1;
        m_psel   = int'(cfg_sel);
        m_pshift = int'(cfg_shift);
      end
    end
    m_cyc++;
  endtask

  task automatic checkOutput();
    check("mult_en",      mult_en,      m_en[0]);
    check("sample_en",    sample_en,    m_en[1]);
    check("adsr_en",      adsr_en,      m_en[2]);
    check("cfg_err",      cfg_err,      m_err);
    check("cfg_ready",    cfg_ready,    !m_pend);
    check("shift_mult",   shift_mult,   m_shift[0]);
    check("shift_sample", shift_sample, m_shift[1]);
    check("shift_adsr",   shift_adsr,   m_shift[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [4:0] shift);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_shift = shift;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mult_en"},   mult_en,      0);
    check({tag, "_sample_en"}, sample_en,    0);
    check({tag, "_adsr_en"},   adsr_en,      0);
    check({tag, "_cfg_err"},   cfg_err,      0);
    check({tag, "_cfg_ready"}, cfg_ready,    1);
    check({tag, "_shift_m"},   shift_mult,   5);
    check({tag, "_shift_s"},   shift_sample, 9);
    check({tag, "_shift_a"},   shift_adsr,   18);
  endtask

  task automatic wait_sample(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_en && n < 40);
  endtask

  // Runs n cycles from a fresh phase and checks first-strobe timing/periods.
  task automatic period_run(input string tag, input int n);
    int first_m, last_m, first_s, last_s, n_adsr;
    first_m = -1; last_m = -1; first_s = -1; last_s = -1; n_adsr = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (mult_en) begin
        if (first_m < 0) first_m = i;
        else check({tag, "_mult_period"}, i - last_m, 32);
        last_m = i;
      end
      if (sample_en) begin
        if (first_s < 0) first_s = i;
        else check({tag, "_sample_period"}, i - last_s, 512);
        last_s = i;
      end
      if (adsr_en) n_adsr++;
    end
    check({tag, "_first_mult_cycle"},   first_m + 1, 33);
    check({tag, "_first_sample_cycle"}, first_s + 1, 513);
    check({tag, "_adsr_count"},         n_adsr, 0);
  endtask

  initial begin
    int waited, n, n_adsr;
    bit expect_s;

    tbl[0] = '{2'd3, 5'd4,  1'b1, 1'b1, 5,  9, 18};
    tbl[1] = '{2'd0, 5'd19, 1'b1, 1'b1, 5,  9, 18};
    tbl[2] = '{2'd2, 5'd31, 1'b1, 1'b1, 5,  9, 18};
    tbl[3] = '{2'd0, 5'd18, 1'b0, 1'b0, 18, 9, 18};
    tbl[4] = '{2'd0, 5'd5,  1'b0, 1'b0, 5,  9, 18};
    tbl[5] = '{2'd1, 5'd0,  1'b0, 1'b0, 5,  0, 18};
    tbl[6] = '{2'd1, 5'd9,  1'b0, 1'b0, 5,  9, 18};
    tbl[7] = '{2'd2, 5'd18, 1'b0, 1'b0, 5,  9, 18};

    rstn = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_shift = '0;
    m_cyc = 0;
    #12;
    check_reset_values("reset");
    model_reset();
    #5 rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].shift);
      check($sformatf("tbl%0d_err", i),   cfg_err,   tbl[i].exp_err);
      check($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].exp_ready);
      tick();
      check($sformatf("tbl%0d_shift_m", i), shift_mult,   tbl[i].exp_m);
      check($sformatf("tbl%0d_shift_s", i), shift_sample, tbl[i].exp_s);
      check($sformatf("tbl%0d_shift_a", i), shift_adsr,   tbl[i].exp_a);
      check($sformatf("tbl%0d_ready_back", i), cfg_ready, 1);
    end

    run = 1'b1;
    period_run("run1", 1200);

    // Sample reconfig mid-period waits for the 512-cycle period to finish.
    applyStimulus(2'd1, 5'd3);
    check("cfg_ready_held", cfg_ready, 0);
    waited = 0;
    while (!cfg_ready && waited < 600) begin
      tick();
      waited++;
    end
    check("cfg_ready_wait", waited, 3 * 512 - 1201);
    check("sample_at_apply", sample_en, 1);
    check("shift_sample_new", shift_sample, 3);
    for (int k = 0; k < 2; k++) begin
      wait_sample(n);
      check("sample_gap8", n, 8);
    end

    run = 1'b0;
    tick();
    applyStimulus(2'd2, 5'd4);
    tick();
    applyStimulus(2'd1, 5'd2);
    tick();
    check("shift_adsr_4", shift_adsr, 4);
    check("shift_sample_2", shift_sample, 2);
    run = 1'b1;
    n_adsr = 0;
    expect_s = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (expect_s) check("sample_after_adsr", sample_en, 1);
      expect_s = 1'b0;
      if (adsr_en) begin
        n_adsr++;
        check("sample_low_on_adsr", sample_en, 0);
        expect_s = 1'b1;
      end
    end
    check("adsr_count_16", n_adsr, 6);

    run = 1'b0;
    tick();
    applyStimulus(2'd1, 5'd0);
    tick();
    applyStimulus(2'd2, 5'd1);
    tick();
    run = 1'b1;
    n_adsr = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (adsr_en) n_adsr++;
    end
    check("adsr_count_2", n_adsr, 20);

    // Asynchronous reset in the middle of a cycle with a config pending.
    run = 1'b1;
    applyStimulus(2'd2, 5'd12);
    check("pend_before_reset", cfg_ready, 0);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    #3 rstn = 1'b1;
    period_run("after_reset", 1100);

    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_shift = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31))
                                              : 5'($urandom_range(0, 5));
      tick();
    end
    cfg_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
